// File: rtl/pipe_rr_sequencer.sv
// Round-robin sequencer feeding a two-stage registered pipeline with a
// valid/ready output; one requester is granted per cycle when stage 1 can accept.
module pipe_rr_sequencer #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [IDW-1:0]     out_id,
  output logic               busy
);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PART, OCC_FULL, OCC_STALL} occ_t;

  logic           vld_p1, vld_p2;
  logic [DW-1:0]  data_p1, data_p2;
  logic [IDW-1:0] id_p1, id_p2;
  logic [IDW-1:0] last_gnt;

  occ_t           occ;
  logic           adv1, adv2;
  logic           win_found, grant;
  logic [IDW-1:0] win_idx;
  logic [DW-1:0]  sel_data;

  always_comb begin
    occ = OCC_EMPTY;
    if (vld_p1 && vld_p2) occ = out_ready ? OCC_FULL : OCC_STALL;
    else if (vld_p1 || vld_p2) occ = OCC_PART;
  end

  assign adv2 = !vld_p2 || out_ready;
  assign adv1 = (occ != OCC_STALL);

  // Scan from the requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_gnt) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  // Nothing can be captured while reset is held, so no grant is shown then.
  assign grant    = win_found && adv1 && rst_n;
  assign sel_data = req_data[int'(win_idx)*DW +: DW];

  always_comb begin
    gnt = '0;
    if (grant) gnt[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      id_p1    <= '0;
      vld_p2   <= 1'b0;
      data_p2  <= '0;
      id_p2    <= '0;
      last_gnt <= IDW'(NREQ - 1);
    end else begin
      // stage 1 -> stage 2
      if (adv2) begin
        vld_p2  <= vld_p1;
        data_p2 <= data_p1;
        id_p2   <= id_p1;
      end
      // arbiter -> stage 1
      if (adv1) begin
        vld_p1 <= grant;
        if (grant) begin
          data_p1 <= sel_data;
          id_p1   <= win_idx;
        end
      end
      if (grant) last_gnt <= win_idx;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_id    = id_p2;
  assign busy      = vld_p1 || vld_p2;

endmodule

// File: tb/tb_pipe_rr_sequencer.sv
// Bench for pipe_rr_sequencer: vector table, directed corner sequences and a
// randomized run against a slot-based reference model.
module tb_pipe_rr_sequencer;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               busy;

  int checks = 0;
  int errors = 0;

  pipe_rr_sequencer #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  rq;
    logic [31:0] dat;
    bit          rdy;
    logic [3:0]  eg;
    bit          ev;
    logic [7:0]  ed;
    logic [1:0]  ei;
    bit          eb;
  } vec_t;

  typedef struct {
    bit v;
    int id;
    int d;
  } slot_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Inputs are already driven; compare at the falling edge, then move past the next rising edge.
  task automatic step_chk(input string nm, input logic [3:0] eg, input bit ev,
                          input logic [7:0] ed, input logic [1:0] ei, input bit eb);
    @(negedge clk);
    chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      chk({nm, ".out_data"}, 32'(out_data), 32'(ed));
      chk({nm, ".out_id"}, 32'(out_id), 32'(ei));
    end
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    @(posedge clk);
    #1;
  endtask

  vec_t  vt[$];
  slot_t st1, st2;
  int    last;
  bit    pend[NREQ];
  int    pdat[NREQ];

  initial begin
    // single grant, then four-way rotation draining back to idle
    vt.push_back('{1, 4'b0001, 32'h000000A5, 1, 4'b0001, 0, 8'h00, 2'd0, 0});
    vt.push_back('{0, 4'b0000, 32'h000000A5, 1, 4'b0000, 0, 8'h00, 2'd0, 1});
    vt.push_back('{0, 4'b0000, 32'h000000A5, 1, 4'b0000, 1, 8'hA5, 2'd0, 1});
    vt.push_back('{0, 4'b0000, 32'h000000A5, 1, 4'b0000, 0, 8'h00, 2'd0, 0});
    vt.push_back('{1, 4'b1111, 32'h13121110, 1, 4'b0001, 0, 8'h00, 2'd0, 0});
    vt.push_back('{0, 4'b1111, 32'h13121110, 1, 4'b0010, 0, 8'h00, 2'd0, 1});
    vt.push_back('{0, 4'b1111, 32'h13121110, 1, 4'b0100, 1, 8'h10, 2'd0, 1});
    vt.push_back('{0, 4'b1111, 32'h13121110, 1, 4'b1000, 1, 8'h11, 2'd1, 1});
    vt.push_back('{0, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h12, 2'd2, 1});
    vt.push_back('{0, 4'b0000, 32'h13121110, 1, 4'b0000, 1, 8'h13, 2'd3, 1});
    vt.push_back('{0, 4'b0000, 32'h13121110, 1, 4'b0000, 1, 8'h10, 2'd0, 1});
    vt.push_back('{0, 4'b0000, 32'h13121110, 1, 4'b0000, 0, 8'h00, 2'd0, 0});

    // reset state, with requests present while reset is held
    rst_n = 1'b0;
    req = 4'b1111;
    req_data = 32'h13121110;
    out_ready = 1'b1;
    #12;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_data", 32'(out_data), 32'h0);
    chk("rst.out_id", 32'(out_id), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    do_reset();
    for (int c = 0; c < 5; c++) step_chk("idle", 4'b0000, 0, 8'h00, 2'd0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      req = vt[i].rq;
      req_data = vt[i].dat;
      out_ready = vt[i].rdy;
      step_chk($sformatf("vec%0d", i), vt[i].eg, vt[i].ev, vt[i].ed, vt[i].ei, vt[i].eb);
    end

    // full pipeline stalled for three cycles, then resumes in order
    do_reset();
    req = 4'b1111;
    req_data = 32'h13121110;
    out_ready = 1'b0;
    step_chk("stall0", 4'b0001, 0, 8'h00, 2'd0, 0);
    step_chk("stall1", 4'b0010, 0, 8'h00, 2'd0, 1);
    for (int c = 0; c < 3; c++) step_chk("stall_hold", 4'b0000, 1, 8'h10, 2'd0, 1);
    out_ready = 1'b1;
    step_chk("resume0", 4'b0100, 1, 8'h10, 2'd0, 1);
    step_chk("resume1", 4'b1000, 1, 8'h11, 2'd1, 1);
    req = 4'b0000;
    step_chk("resume2", 4'b0000, 1, 8'h12, 2'd2, 1);
    step_chk("resume3", 4'b0000, 1, 8'h13, 2'd3, 1);
    step_chk("resume4", 4'b0000, 0, 8'h00, 2'd0, 0);

    // sparse requesters: pointer skips idle ones and survives idle cycles
    do_reset();
    req_data = 32'h44332211;
    req = 4'b0001;
    step_chk("rr0", 4'b0001, 0, 8'h00, 2'd0, 0);
    req = 4'b0101;
    step_chk("rr1", 4'b0100, 0, 8'h00, 2'd0, 1);
    step_chk("rr2", 4'b0001, 1, 8'h11, 2'd0, 1);
    req = 4'b0000;
    step_chk("rr3", 4'b0000, 1, 8'h33, 2'd2, 1);
    step_chk("rr4", 4'b0000, 1, 8'h11, 2'd0, 1);
    step_chk("rr5", 4'b0000, 0, 8'h00, 2'd0, 0);
    req = 4'b0101;
    step_chk("rr6", 4'b0100, 0, 8'h00, 2'd0, 0);
    req = 4'b0000;
    step_chk("rr7", 4'b0000, 0, 8'h00, 2'd0, 1);
    step_chk("rr8", 4'b0000, 1, 8'h33, 2'd2, 1);

    // asynchronous reset with both stages valid
    do_reset();
    req = 4'b1111;
    req_data = 32'h13121110;
    out_ready = 1'b0;
    step_chk("arst0", 4'b0001, 0, 8'h00, 2'd0, 0);
    step_chk("arst1", 4'b0010, 0, 8'h00, 2'd0, 1);
    @(negedge clk);
    chk("arst.full_valid", 32'(out_valid), 32'h1);
    chk("arst.full_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'h0);
    chk("arst.busy", 32'(busy), 32'h0);
    chk("arst.gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step_chk("arst2", 4'b0001, 0, 8'h00, 2'd0, 0);
    req = 4'b0000;
    step_chk("arst3", 4'b0000, 0, 8'h00, 2'd0, 1);
    step_chk("arst4", 4'b0000, 1, 8'h10, 2'd0, 1);
    step_chk("arst5", 4'b0000, 0, 8'h00, 2'd0, 0);

    // randomized traffic against the reference model
    do_reset();
    last = NREQ - 1;
    st1 = '{0, 0, 0};
    st2 = '{0, 0, 0};
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0;
      pdat[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int  w;
      bit  stall;
      logic [3:0] eg;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1;
          pdat[i] = int'($urandom_range(255, 0));
        end else if (pend[i] && $urandom_range(15, 0) == 0) begin
          pend[i] = 0;
        end
        req[i] = pend[i];
        req_data[i*DW +: DW] = DW'(pdat[i]);
      end
      out_ready = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      stall = st1.v && st2.v && !out_ready;
      w = -1;
      if (!stall) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (w < 0 && pend[(last + k) % NREQ]) w = (last + k) % NREQ;
        end
      end
      eg = (w >= 0) ? 4'(1 << w) : 4'b0000;
      chk("rnd.gnt", 32'(gnt), 32'(eg));
      chk("rnd.out_valid", 32'(out_valid), 32'(st2.v));
      if (st2.v) begin
        chk("rnd.out_data", 32'(out_data), 32'(st2.d));
        chk("rnd.out_id", 32'(out_id), 32'(st2.id));
      end
      chk("rnd.busy", 32'(busy), 32'(st1.v || st2.v));
      if (!st2.v || out_ready) begin
        st2 = st1;
        st1.v = 0;
      end
      if (!st1.v && w >= 0) begin
        st1 = '{1, w, pdat[w]};
        last = w;
        pend[w] = 0;
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
